// File: rtl/axi_4_lite_mst.sv
// axi_4_lite_mst: single-outstanding AXI4-Lite master driven by a simple command/response port.
module axi_4_lite_mst #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESETN,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WE,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  input  logic [1:0]              M_AXI_BRESP,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  output logic                    BUSY
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;
  typedef struct packed {
    state_t                  state;
    logic                    cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, busy;
    logic [1:0]              resp;
    logic [DATA_WIDTH-1:0]   rdata, wdata;
    logic [ADDR_WIDTH-1:0]   awaddr, araddr;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic [CW-1:0]           cnt;
  } regs_t;
  regs_t r, n;
  logic  tmo, abort, take_b;
  assign tmo = r.cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      r           <= '0;
      r.cmd_ready <= 1'b1;
    end else begin
      r <= n;
    end
  always_comb begin
    n      = r;
    abort  = 1'b0;
    take_b = 1'b0;
    case (r.state)
      IDLE: if (CMD_VALID) begin
        n.cmd_ready = 1'b0;
        n.awaddr    = CMD_ADDR;
        n.araddr    = CMD_ADDR;
        n.wdata     = CMD_WDATA;
        n.wstrb     = CMD_WSTRB;
        n.awvalid   = CMD_WE;
        n.wvalid    = CMD_WE;
        n.bready    = CMD_WE;
        n.arvalid   = !CMD_WE;
        n.state     = CMD_WE ? WRITE : RD_ADDR;
      end
      WRITE: begin
        n.awvalid = r.awvalid && !M_AXI_AWREADY;
        n.wvalid  = r.wvalid && !M_AXI_WREADY;
        if (n.awvalid || n.wvalid) abort = tmo;
        else if (M_AXI_BVALID) take_b = 1'b1;
        else n.state = WR_RESP;
      end
      WR_RESP: if (M_AXI_BVALID) take_b = 1'b1; else abort = tmo;
      RD_ADDR: if (M_AXI_ARREADY) begin
        n.arvalid = 1'b0;
        n.rready  = 1'b1;
        n.state   = RD_DATA;
      end else abort = tmo;
      RD_DATA: if (M_AXI_RVALID) begin
        n.rready    = 1'b0;
        n.rdata     = M_AXI_RDATA;
        n.resp      = M_AXI_RRESP;
        n.rsp_valid = 1'b1;
        n.state     = RESP;
      end else abort = tmo;
      RESP: if (RSP_READY) begin
        n.rsp_valid = 1'b0;
        n.cmd_ready = 1'b1;
        n.state     = IDLE;
      end
      default: n.state = IDLE;
    endcase
    if (take_b) begin
      n.bready    = 1'b0;
      n.resp      = M_AXI_BRESP;
      n.rdata     = '0;
      n.rsp_valid = 1'b1;
      n.state     = RESP;
    end
    // a hung slave: release the bus and report DECERR locally
    if (abort) begin
      {n.awvalid, n.wvalid, n.bready, n.arvalid, n.rready} = '0;
      n.resp      = 2'b11;
      n.rdata     = '0;
      n.rsp_valid = 1'b1;
      n.state     = RESP;
    end
    n.busy = n.state != IDLE;
    n.cnt  = (n.state != r.state || r.state == IDLE || r.state == RESP) ? '0 : r.cnt + 1'b1;
  end
  assign CMD_READY     = r.cmd_ready;
  assign RSP_VALID     = r.rsp_valid;
  assign RSP_RDATA     = r.rdata;
  assign RSP_RESP      = r.resp;
  assign M_AXI_AWVALID = r.awvalid;
  assign M_AXI_AWADDR  = r.awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = r.wvalid;
  assign M_AXI_WDATA   = r.wdata;
  assign M_AXI_WSTRB   = r.wstrb;
  assign M_AXI_BREADY  = r.bready;
  assign M_AXI_ARVALID = r.arvalid;
  assign M_AXI_ARADDR  = r.araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = r.rready;
  assign BUSY          = r.busy;
endmodule

// File: tb/tb_axi_4_lite_mst.sv
// tb_axi_4_lite_mst: directed scenarios against a configurable-latency AXI4-Lite slave model.
module tb_axi_4_lite_mst;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        CMD_VALID, CMD_READY, CMD_WE, RSP_VALID, RSP_READY, BUSY;
  logic [31:0] CMD_ADDR, CMD_WDATA, RSP_RDATA;
  logic [3:0]  CMD_WSTRB;
  logic [1:0]  RSP_RESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  int          checks = 0, errors = 0;
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
  logic [31:0] rdata_v = '0;
  int          aw_hs, w_hs, ar_hs, aw_vcyc, w_vcyc, ar_wait, stab_err, bready_err;
  logic [31:0] aw_seen, w_seen, ar_seen;
  logic [3:0]  ws_seen;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_got, w_got, b_pend, r_pend, b_hs, r_hs, aw_pd, w_pd;
  logic [31:0] rd;
  logic [1:0]  rr;
  logic        p1;
  always #5 clk = ~clk;
  axi_4_lite_mst #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WE(CMD_WE), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .BUSY(BUSY)
  );
  // Slave model: decides its inputs at each falling edge so they are stable for the next rising edge.
  initial begin
    {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID} = '0;
    M_AXI_BRESP = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID} = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        {aw_got, w_got, b_pend, r_pend, b_hs, r_hs, aw_pd, w_pd} = '0;
      end else begin
        if (b_hs) M_AXI_BVALID = 1'b0;
        if (r_hs) M_AXI_RVALID = 1'b0;
        if (b_pend && !M_AXI_BVALID) begin
          if (b_cnt >= b_dly) begin M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp_v; end
          else b_cnt++;
        end
        if (r_pend && !M_AXI_RVALID) begin
          if (r_cnt >= r_dly) begin M_AXI_RVALID = 1'b1; M_AXI_RDATA = rdata_v; M_AXI_RRESP = rresp_v; end
          else r_cnt++;
        end
        if (aw_pd && !M_AXI_AWVALID) stab_err++;
        if (w_pd && !M_AXI_WVALID) stab_err++;
        if (M_AXI_AWVALID) aw_vcyc++;
        if (M_AXI_WVALID) w_vcyc++;
        M_AXI_AWREADY = M_AXI_AWVALID && aw_cnt >= aw_dly;
        M_AXI_WREADY  = M_AXI_WVALID && w_cnt >= w_dly;
        M_AXI_ARREADY = M_AXI_ARVALID && ar_cnt >= ar_dly;
        aw_cnt = (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
        w_cnt  = (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
        ar_cnt = (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
        if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_wait++;
        aw_pd = M_AXI_AWVALID && !M_AXI_AWREADY;
        w_pd  = M_AXI_WVALID && !M_AXI_WREADY;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_hs++; aw_seen = M_AXI_AWADDR; aw_got = 1; end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          w_hs++; w_seen = M_AXI_WDATA; ws_seen = M_AXI_WSTRB; w_got = 1;
        end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_hs++; ar_seen = M_AXI_ARADDR; r_pend = 1; r_cnt = 0; end
        if ((M_AXI_AWVALID || M_AXI_WVALID || b_pend) && !M_AXI_BREADY) bready_err++;
        b_hs = M_AXI_BVALID && M_AXI_BREADY;
        r_hs = M_AXI_RVALID && M_AXI_RREADY;
        if (b_hs) b_pend = 0;
        if (r_hs) r_pend = 0;
      end
    end
  end
  task automatic slv_clr();
    aw_hs = 0; w_hs = 0; ar_hs = 0; aw_vcyc = 0; w_vcyc = 0; ar_wait = 0; stab_err = 0; bready_err = 0;
    aw_seen = '0; w_seen = '0; ar_seen = '0; ws_seen = '0;
  endtask
  task automatic cmd(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] o_rd, output logic [1:0] o_rr, output logic pulse1);
    int n;
    @(negedge clk);
    n = 0;
    while (!CMD_READY && n < 50) begin @(negedge clk); n++; end
    CMD_VALID = 1'b1; CMD_WE = we; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
    @(negedge clk);
    CMD_VALID = 1'b0;
    n = 0;
    while (!RSP_VALID && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (RSP_VALID !== 1'b1) begin errors++; $display("FAIL rsp_wait: RSP_VALID=%b required 1", RSP_VALID); end
    o_rd = RSP_RDATA;
    o_rr = RSP_RESP;
    @(negedge clk);
    pulse1 = !RSP_VALID;
  endtask
  task automatic test_reset();
    #12;
    checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", CMD_READY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    checks++;
    if ({RSP_VALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 6'b0) begin
      errors++; $display("FAIL rst_valids: got %b want 000000",
        {RSP_VALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
    end
    checks++;
    if ({RSP_RDATA, RSP_RESP, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR} !== '0) begin
      errors++; $display("FAIL rst_data: rdata %h resp %b awaddr %h wdata %h wstrb %h araddr %h want all 0",
        RSP_RDATA, RSP_RESP, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_ARADDR);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL rel_cmd_ready: got %b want 1", CMD_READY); end
  endtask
  task automatic test_write();
    slv_clr();
    cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, rd, rr, p1);
    checks++; if (rr !== 2'b00) begin errors++; $display("FAIL wr_resp: got %b want 00", rr); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rd); end
    checks++; if (p1 !== 1'b1) begin errors++; $display("FAIL wr_rsp_pulse: RSP_VALID longer than one cycle"); end
    checks++; if (aw_hs !== 1 || w_hs !== 1) begin errors++; $display("FAIL wr_hs_count: aw %0d w %0d want 1 1", aw_hs, w_hs); end
    checks++; if (aw_seen !== 32'h4) begin errors++; $display("FAIL wr_awaddr: got %h want 4", aw_seen); end
    checks++;
    if (w_seen !== 32'hDEAD_BEEF || ws_seen !== 4'hF) begin
      errors++; $display("FAIL wr_wdata: got %h/%h want deadbeef/f", w_seen, ws_seen);
    end
    checks++; if (M_AXI_AWPROT !== 3'b0 || M_AXI_ARPROT !== 3'b0) begin errors++; $display("FAIL prot: got %b %b want 000", M_AXI_AWPROT, M_AXI_ARPROT); end
  endtask
  task automatic test_read();
    slv_clr();
    ar_dly = 3; rdata_v = 32'hDEAD_BEEF; rresp_v = 2'b00;
    cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0, rd, rr, p1);
    ar_dly = 0;
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++; if (rr !== 2'b00) begin errors++; $display("FAIL rd_resp: got %b want 00", rr); end
    checks++; if (ar_wait !== 3) begin errors++; $display("FAIL rd_ar_wait: got %0d want 3", ar_wait); end
    checks++; if (ar_hs !== 1 || ar_seen !== 32'h4) begin errors++; $display("FAIL rd_ar: hs %0d addr %h want 1 4", ar_hs, ar_seen); end
  endtask
  task automatic test_write_skew();
    slv_clr();
    aw_dly = 0; w_dly = 5;
    cmd(1'b1, 32'h0000_0008, 32'h1111_2222, 4'hF, rd, rr, p1);
    checks++; if (rr !== 2'b00) begin errors++; $display("FAIL skew1_resp: got %b want 00", rr); end
    checks++; if (aw_vcyc !== 1 || w_vcyc !== 6) begin errors++; $display("FAIL skew1_valid_cycles: aw %0d w %0d want 1 6", aw_vcyc, w_vcyc); end
    aw_vcyc = 0; w_vcyc = 0;
    aw_dly = 4; w_dly = 0;
    cmd(1'b1, 32'h0000_000C, 32'h3333_4444, 4'hF, rd, rr, p1);
    aw_dly = 0;
    checks++; if (rr !== 2'b00) begin errors++; $display("FAIL skew2_resp: got %b want 00", rr); end
    checks++; if (aw_vcyc !== 5 || w_vcyc !== 1) begin errors++; $display("FAIL skew2_valid_cycles: aw %0d w %0d want 5 1", aw_vcyc, w_vcyc); end
    checks++; if (aw_hs !== 2 || w_hs !== 2) begin errors++; $display("FAIL skew_hs: aw %0d w %0d want 2 2", aw_hs, w_hs); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL skew_early_drop: got %0d want 0", stab_err); end
    checks++; if (bready_err !== 0) begin errors++; $display("FAIL skew_bready: got %0d low cycles want 0", bready_err); end
  endtask
  task automatic test_timeout();
    slv_clr();
    ar_dly = 1000;
    cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, rr, p1);
    ar_dly = 0;
    checks++; if (rr !== 2'b11) begin errors++; $display("FAIL to_resp: got %b want 11", rr); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", rd); end
    checks++; if (ar_wait !== 16) begin errors++; $display("FAIL to_cycles: ARVALID high %0d cycles want 16", ar_wait); end
    checks++; if (M_AXI_ARVALID !== 1'b0 || ar_hs !== 0) begin errors++; $display("FAIL to_arvalid: arvalid %b hs %0d want 0 0", M_AXI_ARVALID, ar_hs); end
    rdata_v = 32'h1234_5678;
    cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, rr, p1);
    checks++; if (rd !== 32'h1234_5678 || rr !== 2'b00) begin errors++; $display("FAIL to_next: got %h/%b want 12345678/00", rd, rr); end
  endtask
  task automatic test_slave_err();
    slv_clr();
    bresp_v = 2'b10;
    cmd(1'b1, 32'h0000_0020, 32'h0000_A5A5, 4'h3, rd, rr, p1);
    bresp_v = 2'b00;
    checks++; if (rr !== 2'b10) begin errors++; $display("FAIL slverr_resp: got %b want 10", rr); end
    checks++; if (ws_seen !== 4'h3) begin errors++; $display("FAIL slverr_wstrb: got %h want 3", ws_seen); end
    rresp_v = 2'b10; rdata_v = 32'h0000_CAFE;
    cmd(1'b0, 32'h0000_0024, 32'h0, 4'h0, rd, rr, p1);
    rresp_v = 2'b00;
    checks++; if (rr !== 2'b10 || rd !== 32'h0000_CAFE) begin errors++; $display("FAIL rd_err: got %h/%b want cafe/10", rd, rr); end
  endtask
  task automatic test_reset_mid();
    int n;
    slv_clr();
    RSP_READY = 1'b0; r_dly = 1000;
    @(negedge clk);
    CMD_VALID = 1'b1; CMD_WE = 1'b0; CMD_ADDR = 32'h0000_0030;
    @(negedge clk);
    CMD_VALID = 1'b0;
    n = 0;
    while (!M_AXI_RREADY && n < 20) begin @(negedge clk); n++; end
    checks++; if (M_AXI_RREADY !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL mid_rd_data: rready %b busy %b want 1 1", M_AXI_RREADY, BUSY); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({RSP_VALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, BUSY} !== 7'b0) begin
      errors++; $display("FAIL mid_async: got %b want 0000000",
        {RSP_VALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, BUSY});
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || RSP_VALID !== 1'b0) begin
      errors++; $display("FAIL mid_release: cmd_ready %b busy %b rsp_valid %b want 1 0 0", CMD_READY, BUSY, RSP_VALID);
    end
    RSP_READY = 1'b1; r_dly = 0;
  endtask
  initial begin
    CMD_VALID = 1'b0; CMD_WE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_WSTRB = '0; RSP_READY = 1'b1;
    slv_clr();
    test_reset();
    test_write();
    test_read();
    test_write_skew();
    test_timeout();
    test_slave_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/axi_4_lite_mst.md
Name: axi_4_lite_mst

Overview:
- Single-outstanding AXI4-Lite master bridge that drives the team's AXI4-Lite register-file slave.
- Accepts one simple command (read or write) on a valid/ready command port and runs the matching AXI4-Lite transaction.
- Returns read data and response on a valid/ready response port.
- Includes a per-transaction timeout so a hung slave cannot stall the local logic.

Parameters:
- ADDR_WIDTH, 32, width of the AXI address and CMD_ADDR.
- DATA_WIDTH, 32, width of the data buses; STRB width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, cycles allowed per waiting state before abort; must be ≥2.

Ports:
- M_AXI_ACLK  in  1  clock; all logic on its rising edge.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY.
- CMD_WE  in  1  1=write, 0=read.
- CMD_ADDR  in  ADDR_WIDTH  byte address.
- CMD_WDATA  in  DATA_WIDTH  write data.
- CMD_WSTRB  in  DATA_WIDTH/8  byte strobes.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumed when RSP_VALID && RSP_READY.
- RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- RSP_RESP  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR; timeout reports 11.
- M_AXI_AWVALID/AWREADY  out/in  1  write address handshake.
- M_AXI_AWADDR  out  ADDR_WIDTH.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_WVALID/WREADY  out/in  1  write data handshake.
- M_AXI_WDATA  out  DATA_WIDTH.
- M_AXI_WSTRB  out  DATA_WIDTH/8.
- M_AXI_BVALID/BREADY  in/out  1  write response handshake.
- M_AXI_BRESP  in  2.
- M_AXI_ARVALID/ARREADY  out/in  1  read address handshake.
- M_AXI_ARADDR  out  ADDR_WIDTH.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_RVALID/RREADY  in/out  1  read data handshake.
- M_AXI_RDATA  in  DATA_WIDTH.
- M_AXI_RRESP  in  2.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; all VALID/READY outputs 0 except CMD_READY=1; RSP_RDATA=0; RSP_RESP=00; address, data and strobe outputs 0; timeout counter 0.
- Reset mid-transaction aborts immediately: no response is produced and all AXI valids drop asynchronously.
- All outputs are registered.
- States: IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: CMD_READY=1. On accept:
  - Latch address, data and strobes onto the AXI buses; clear the timeout counter; CMD_READY=0 next cycle.
  - CMD_WE=1: go to WRITE; assert AWVALID and WVALID together next cycle.
  - CMD_WE=0: go to RD_ADDR; assert ARVALID next cycle.
- WRITE: AW and W handshakes are tracked independently.
  - Each VALID is held stable until its own READY is sampled high, then drops the following cycle.
  - Both handshakes may complete in the same cycle or in either order.
  - BREADY is asserted on entry to WRITE and held through WR_RESP.
  - Once both handshakes are done, go to WR_RESP. If BVALID arrives in the same cycle as the last handshake, it is accepted and WR_RESP is skipped.
- WR_RESP: on BVALID, capture BRESP, set RSP_RDATA=0, drop BREADY, go to RESP.
- RD_ADDR: hold ARVALID and ARADDR until ARREADY; then drop ARVALID, raise RREADY, go to RD_DATA.
- RD_DATA: on RVALID, capture RDATA and RRESP, drop RREADY, go to RESP.
- RESP: RSP_VALID=1, held with stable RSP_RDATA/RSP_RESP until RSP_READY. Then return to IDLE; CMD_READY=1 the next cycle.
  - Minimum command-to-command spacing is therefore 4 cycles, with a zero-wait slave and RSP_READY tied high.
- Timeout:
  - The counter increments each cycle spent in WRITE, WR_RESP, RD_ADDR or RD_DATA, and resets on every state change.
  - When it reaches TIMEOUT_CYCLES-1 without progress: drop every AXI valid/ready, set RSP_RESP=11 and RSP_RDATA=0, go to RESP.
  - Late AXI responses arriving after an abort are ignored: BREADY and RREADY are low in IDLE/RESP, and the master does not issue a new command until BUSY falls.
- Slave error responses (SLVERR/DECERR) pass through unmodified; RDATA is still forwarded on read errors.
- CMD_* inputs are ignored outside IDLE.

Test Plan:
- Write 0x0000_0004, data 0xDEAD_BEEF, strobe 0xF; slave with zero-wait AW/W/B → exactly one AW and one W handshake with matching values; RSP_RESP=00, RSP_RDATA=0, RSP_VALID one cycle.
- Read 0x0000_0004 after the write; slave returns 0xDEAD_BEEF with RRESP=00 after 3 wait cycles → RSP_RDATA=0xDEAD_BEEF, RSP_RESP=00; ARVALID held stable 3 cycles.
- Write with WREADY 5 cycles after AWREADY, then write with WREADY before AWREADY → AWVALID/WVALID each drop only after their own handshake; BREADY high throughout; both complete with OKAY.
- Read with ARREADY stuck low, TIMEOUT_CYCLES=16 → abort after 16 cycles; RSP_RESP=11, RSP_RDATA=0; ARVALID low afterwards; next command is accepted.
- Slave returns BRESP=10 on a write, strobe 0x3 → RSP_RESP=10; WSTRB observed as 0x3.
- Assert reset during RD_DATA with RSP_READY held low → all valids 0 within the reset cycle, no RSP_VALID; after release CMD_READY=1 and BUSY=0.
